// File: rtl/syn_fetch_queue_if.sv
// Fetch-queue output handshake bundle between the fetch queue and IF/ID.
//   out_valid : head entry valid        (master -> slave)
//   out_ready : IF/ID accepts the head  (slave  -> master)
//   out_pc_4  : head word address + 1   (master -> slave)
//   out_inst  : head instruction        (master -> slave)
interface syn_fetch_queue_if #(
  parameter int unsigned ADDR_BIT = 10
);
  logic                out_valid;
  logic                out_ready;
  logic [ADDR_BIT-1:0] out_pc_4;
  logic [31:0]         out_inst;

  modport master (output out_valid, output out_pc_4, output out_inst, input out_ready);
  modport slave  (input out_valid, input out_pc_4, input out_inst, output out_ready);
endinterface

// File: rtl/syn_fetch_queue.sv
// Instruction fetch queue upstream of IF/ID: owns the fetch PC, drives the
// instruction memory address and buffers {pc_4, inst} pairs in a FIFO.
// Optional macro FETCH_QUEUE_BYPASS_EN lets an empty queue forward im_inst
// straight to the outputs.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   en                : global enable (0 holds all state, ignores redirect)
//   redirect/_pc      : taken jump/branch flush and new fetch word address
//   halt              : stop fetching, queue still drains
//   im_addr / im_inst : combinational instruction memory port
//   q (master)        : out_valid/out_ready/out_pc_4/out_inst handshake
//   count             : occupied entries
//   pc_dbg            : fetch PC as a byte address
module syn_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_BIT = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         redirect,
  input  logic [ADDR_BIT-1:0]          redirect_pc,
  input  logic                         halt,
  output logic [ADDR_BIT-1:0]          im_addr,
  input  logic [31:0]                  im_inst,
  syn_fetch_queue_if.master            q,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  pc_dbg
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_BIT-1:0] pc_4;
    logic [31:0]         inst;
  } entry_t;

  logic [ADDR_BIT-1:0] fetch_pc;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count_q;
  entry_t              mem [DEPTH];

  logic                empty;
  logic                full;
  logic                bypass;
  logic                pop;
  logic                push;
  logic                direct;
  logic                fifo_push;
  logic                fifo_pop;
  logic [ADDR_BIT-1:0] next_pc;
  entry_t              head;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign next_pc = fetch_pc + ADDR_BIT'(1);
  assign head    = mem[rd_ptr];

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue forwards the memory word directly to IF/ID.
  assign bypass = empty & ~halt & ~redirect;
`else
  assign bypass = 1'b0;
`endif

  assign pop       = en & q.out_valid & q.out_ready & ~redirect;
  assign push      = en & ~halt & ~redirect & (~full | pop);
  // A bypassed word consumed this cycle never touches the FIFO.
  assign direct    = bypass & pop;
  assign fifo_push = push & ~direct;
  assign fifo_pop  = pop & ~direct;

  // Head selection: FIFO entry, bypassed memory word, or zeros.
  always_comb begin
    q.out_valid = 1'b0;
    q.out_pc_4  = '0;
    q.out_inst  = '0;
    if (!empty) begin
      q.out_valid = 1'b1;
      q.out_pc_4  = head.pc_4;
      q.out_inst  = head.inst;
    end else if (bypass) begin
      q.out_valid = 1'b1;
      q.out_pc_4  = next_pc;
      q.out_inst  = im_inst;
    end
  end

  assign im_addr = fetch_pc;
  assign count   = count_q;
  assign pc_dbg  = 32'({fetch_pc, 2'b00});

  // Fetch PC, pointers and occupancy; redirect has top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else if (en) begin
      if (redirect) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count_q  <= '0;
      end else begin
        if (push)      fetch_pc <= next_pc;
        if (fifo_push) wr_ptr   <= wr_ptr + PTR_W'(1);
        if (fifo_pop)  rd_ptr   <= rd_ptr + PTR_W'(1);
        case ({fifo_push, fifo_pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Entry storage; contents are masked by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (fifo_push) mem[wr_ptr] <= '{pc_4: next_pc, inst: im_inst};
  end

endmodule

// File: tb/tb_syn_fetch_queue.sv
// Directed self-checking bench for syn_fetch_queue (default build).
// Memory model: word k holds 0x1000_0000 + k.
module tb_syn_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ADDR_BIT = 10;

  logic                clk;
  logic                rst_n;
  logic                en;
  logic                redirect;
  logic [ADDR_BIT-1:0] redirect_pc;
  logic                halt;
  logic [ADDR_BIT-1:0] im_addr;
  logic [31:0]         im_inst;
  logic [2:0]          count;
  logic [31:0]         pc_dbg;

  int checks;
  int errors;

  syn_fetch_queue_if #(.ADDR_BIT(ADDR_BIT)) q ();

  syn_fetch_queue #(.DEPTH(DEPTH), .ADDR_BIT(ADDR_BIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .im_addr     (im_addr),
    .im_inst     (im_inst),
    .q           (q),
    .count       (count),
    .pc_dbg      (pc_dbg)
  );

  assign im_inst = 32'h1000_0000 + 32'(im_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    en = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    q.out_ready = 1'b1;
    #12;
    // reset state
    chk("rst_valid", 64'(q.out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pc_4", 64'(q.out_pc_4), 64'd0);
    chk("rst_inst", 64'(q.out_inst), 64'd0);
    chk("rst_im_addr", 64'(im_addr), 64'd0);
    chk("rst_pc_dbg", 64'(pc_dbg), 64'd0);

    // streaming at one instruction per cycle
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("stream_valid", 64'(q.out_valid), 64'd1);
      chk("stream_pc_4", 64'(q.out_pc_4), 64'(i));
      chk("stream_inst", 64'(q.out_inst), 64'h1000_0000 + 64'(i - 1));
      chk("stream_count", 64'(count), 64'd1);
    end

    // flush to 0, then stall IF/ID for 8 cycles
    redirect = 1'b1;
    redirect_pc = 10'h000;
    q.out_ready = 1'b0;
    step();
    redirect = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_im_addr", 64'(im_addr), 64'd0);
    for (int i = 0; i < 8; i++) step();
    chk("stall_count", 64'(count), 64'd4);
    chk("stall_im_addr", 64'(im_addr), 64'd4);

    // release: full-queue push+pop, instructions 0..5 in order
    q.out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("drain_pc_4", 64'(q.out_pc_4), 64'(j + 1));
      chk("drain_inst", 64'(q.out_inst), 64'h1000_0000 + 64'(j));
      chk("drain_count", 64'(count), 64'd4);
      chk("drain_im_addr", 64'(im_addr), 64'(4 + j));
      step();
    end

    // build count = 3 from 0x50, then redirect to 0x120
    redirect = 1'b1;
    redirect_pc = 10'h050;
    q.out_ready = 1'b0;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pre_redir_count", 64'(count), 64'd3);
    chk("pre_redir_im_addr", 64'(im_addr), 64'h53);
    redirect = 1'b1;
    redirect_pc = 10'h120;
    step();
    redirect = 1'b0;
    chk("redir_count", 64'(count), 64'd0);
    chk("redir_valid", 64'(q.out_valid), 64'd0);
    chk("redir_im_addr", 64'(im_addr), 64'h120);
    chk("redir_pc_dbg", 64'(pc_dbg), 64'h480);
    q.out_ready = 1'b1;
    step();
    chk("redir_first_pc_4", 64'(q.out_pc_4), 64'h121);
    chk("redir_first_inst", 64'(q.out_inst), 64'h1000_0120);

    // wrap at the top of the address space
    redirect = 1'b1;
    redirect_pc = 10'h3FF;
    q.out_ready = 1'b0;
    step();
    redirect = 1'b0;
    chk("wrap_im_addr", 64'(im_addr), 64'h3FF);
    step();
    chk("wrap_pc_4", 64'(q.out_pc_4), 64'd0);
    chk("wrap_inst", 64'(q.out_inst), 64'h1000_03FF);
    chk("wrap_next_addr", 64'(im_addr), 64'd0);
    step();
    q.out_ready = 1'b1;
    step();
    chk("wrap2_pc_4", 64'(q.out_pc_4), 64'd1);
    chk("wrap2_inst", 64'(q.out_inst), 64'h1000_0000);
    chk("wrap2_count", 64'(count), 64'd2);
    chk("wrap2_im_addr", 64'(im_addr), 64'd2);

    // halt drains two entries, fetch PC holds
    halt = 1'b1;
    step();
    chk("halt1_count", 64'(count), 64'd1);
    step();
    chk("halt2_count", 64'(count), 64'd0);
    chk("halt2_valid", 64'(q.out_valid), 64'd0);
    chk("halt2_pc_4", 64'(q.out_pc_4), 64'd0);
    chk("halt2_inst", 64'(q.out_inst), 64'd0);
    step();
    chk("halt3_im_addr", 64'(im_addr), 64'd2);

    // en = 0 ignores redirect and freezes state
    halt = 1'b0;
    q.out_ready = 1'b0;
    step();
    chk("pre_en_count", 64'(count), 64'd1);
    en = 1'b0;
    redirect = 1'b1;
    redirect_pc = 10'h077;
    q.out_ready = 1'b1;
    step();
    step();
    chk("en0_count", 64'(count), 64'd1);
    chk("en0_im_addr", 64'(im_addr), 64'd3);
    chk("en0_pc_4", 64'(q.out_pc_4), 64'd3);
    chk("en0_inst", 64'(q.out_inst), 64'h1000_0002);

    // asynchronous reset mid-operation
    en = 1'b1;
    redirect = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(q.out_valid), 64'd0);
    chk("arst_im_addr", 64'(im_addr), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/syn_fetch_queue.md
# syn_fetch_queue

Instruction fetch queue sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC, drives the combinational instruction memory address, and buffers fetched `{pc_4, inst}` pairs in a small FIFO. IF/ID pops them under a valid/ready handshake, which decouples fetch from decode stalls. A taken jump or branch from EX flushes the queue and reloads the fetch PC.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `ADDR_BIT`, 10: word-address width of the instruction memory, equal to `IM_ADDR_BIT`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `en`  in  1: global enable; when 0, all state holds and `redirect` is ignored.
- `redirect`  in  1: jump/branch taken in EX (`jumped || branched`).
- `redirect_pc`  in  ADDR_BIT: new word address (`pc_new`).
- `halt`  in  1: stop fetching; queued entries still drain.
- `im_addr`  out  ADDR_BIT: instruction memory word address, equal to `fetch_pc`.
- `im_inst`  in  32: instruction at `im_addr`, combinational.
- `out_valid`  out  1: head entry is valid.
- `out_ready`  in  1: IF/ID accepts the head this cycle.
- `out_pc_4`  out  ADDR_BIT: word address of the head instruction + 1.
- `out_inst`  out  32: head instruction.
- `count`  out  clog2(DEPTH+1): occupied entries.
- `pc_dbg`  out  32: `{20'd0-equivalent zero pad, fetch_pc, 2'b00}`, a byte address.

## Operation
- State: `fetch_pc`, a circular buffer of DEPTH × {ADDR_BIT + 32}, read/write pointers of clog2(DEPTH) bits, and `count`.
- `pop = en & out_valid & out_ready & ~redirect`.
- `push = en & ~halt & ~redirect & (count < DEPTH | pop)`. A simultaneous push and pop at full is legal.
- On push:
  - The entry {`fetch_pc + 1`, `im_inst`} is written at the write pointer.
  - `fetch_pc` increments, wrapping modulo 2^ADDR_BIT.
  - The wrapped value 0 is stored as `pc_4` for the entry at address 2^ADDR_BIT−1.
- On pop: the read pointer advances. Pointers wrap naturally at DEPTH.
- Count update: push only +1, pop only −1, both or neither unchanged.
- Redirect, when `en` = 1, has the highest priority:
  - Pointers and `count` go to 0 and all entries are discarded.
  - `fetch_pc` ← `redirect_pc`.
  - No push or pop occurs that cycle.
- Halt: with `halt` = 1, no push occurs and `fetch_pc` holds. Pops continue until empty. Redirect still applies under halt.
- Output when `out_valid` = 0: `out_pc_4` and `out_inst` read 0.

## Timing
- Reset values: `fetch_pc` = 0, `count` = 0, `out_valid` = 0, `out_pc_4` = 0, `out_inst` = 0, `im_addr` = 0, `pc_dbg` = 0.
- Without bypass, an instruction fetched in cycle N is visible at the outputs from cycle N+1.
- Steady state at 1 pop/cycle sustains 1 instruction/cycle.
- After redirect in cycle N:
  - `im_addr` = `redirect_pc` in cycle N+1.
  - The first new instruction is valid in cycle N+2 without bypass, or N+1 with bypass.
- `out_valid`, `out_pc_4`, `out_inst` and `count` depend only on registered state, except in bypass mode.
- Reset asserted mid-operation clears all state immediately, asynchronously.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: bypass is enabled.
  - When `count` = 0, `halt` = 0 and `redirect` = 0, the outputs show `out_valid` = 1, `out_inst` = `im_inst`, `out_pc_4` = `fetch_pc + 1` combinationally.
  - If `out_ready` = 1, the instruction is consumed directly: no FIFO write, `fetch_pc` increments, `count` stays 0.
- Undefined: outputs come only from the FIFO, with 1-cycle minimum fetch-to-output latency.

## Test plan
- Reset, memory word k = 0x1000_0000+k, `out_ready` = 1, bypass off:
  - `out_valid` rises in cycle 1.
  - Pops return (`out_pc_4`, `out_inst`) = (1, 0x1000_0000), (2, 0x1000_0001), … with one per cycle.
  - `count` stays 1.
- `out_ready` = 0 for 8 cycles:
  - `count` saturates at 4 and `fetch_pc` stops at 4.
  - Releasing `out_ready` yields instructions 0..3, then 4, in order, with none lost or duplicated.
- Full queue, then `out_ready` = 1:
  - Push and pop occur in the same cycle, `count` stays 4.
  - `fetch_pc` advances by 1 per cycle.
- Redirect with `redirect_pc` = 0x120 while `count` = 3:
  - Next cycle `count` = 0, `out_valid` = 0, `im_addr` = 0x120.
  - The next popped instruction has `out_pc_4` = 0x121.
- `redirect_pc` = 0x3FF (ADDR_BIT = 10):
  - The first entry has `out_pc_4` = 0.
  - The following fetch is from address 0.
- Combined `halt`/`en` checks:
  - `halt` = 1 with `count` = 2: two pops drain, then `out_valid` = 0 and `fetch_pc` is unchanged.
  - `en` = 0 with `redirect` = 1: no state change.
